// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg: shared constants and types for the counter command
// sequencer. Holds the counter mode encodings and the sequencer state type.
package counter_sequencer_pkg;

  // Counter MODO encodings
  localparam logic [1:0] MODE_UP1  = 2'b00;  // up by one
  localparam logic [1:0] MODE_DN1  = 2'b01;  // down by one
  localparam logic [1:0] MODE_DN3  = 2'b10;  // down by three
  localparam logic [1:0] MODE_LOAD = 2'b11;  // parallel load of D

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ctrl_watchdog.sv
// ctrl_watchdog: counts enabled cycles since the last clear and flags expiry
// once TIMEOUT cycles have elapsed. Only compiled when CTRL_TIMEOUT_EN is
// defined, since the sequencer instantiates it only in that build.
`ifdef CTRL_TIMEOUT_EN
module ctrl_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_r;

  // Expiry in the cycle that would complete the TIMEOUT-th enabled cycle
  assign expired = enable && (cnt_r == LAST);

  // Cycle counter: cleared on request, saturates at the expiry point
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= {TW{1'b0}};
    end else if (clear) begin
      cnt_r <= {TW{1'b0}};
    end else if (enable && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + TW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule
`endif

// File: rtl/counter_sequencer.sv
// counter_sequencer: accepts one command at a time, loads the counter with a
// start value, runs it in the requested mode until the requested number of
// RCO pulses has been seen, then pulses DONE (ERR marks abort/timeout).
// Optional feature macro: CTRL_TIMEOUT_EN adds a RUN-phase watchdog that
// aborts a run after TIMEOUT cycles without an RCO.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [1:0]       REQ_MODE,
  input  logic [WIDTH-1:0] REQ_D,
  input  logic [CW-1:0]    REQ_TARGET,
  input  logic             ABORT,
  output logic             CNT_ENABLE,
  output logic [1:0]       CNT_MODO,
  output logic [WIDTH-1:0] CNT_D,
  input  logic             CNT_RCO,
  output logic             DONE,
  output logic             ERR,
  output logic [CW-1:0]    RCO_SEEN
);

  // A zero timeout would make every run expire before it starts
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("counter_sequencer: TIMEOUT must be at least 1");
  end

  seq_state_e       state_r;
  logic             ready_r;
  logic             cnt_enable_r;
  logic [1:0]       cnt_modo_r;
  logic [WIDTH-1:0] cnt_d_r;
  logic             done_r;
  logic             err_r;
  logic [CW-1:0]    rco_seen_r;

  // Command captured at accept
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    target_r;

  logic             final_rco_s;
  logic             wd_expired_s;
  logic             wd_clear_s;
  logic             wd_enable_s;

  // Watchdog runs only in RUN and restarts on every RCO
  assign wd_enable_s = (state_r == S_RUN);
  assign wd_clear_s  = (state_r != S_RUN) || CNT_RCO;

`ifdef CTRL_TIMEOUT_EN
  ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );
`else
  // Without the watchdog a run never times out
  assign wd_expired_s = 1'b0 & wd_clear_s & wd_enable_s;
`endif

  // The RCO that completes the target (target is non-zero whenever in RUN)
  assign final_rco_s = CNT_RCO && (rco_seen_r == (target_r - CW'(1)));

  // Registered outputs; READY is additionally masked while RESET is high
  assign REQ_READY  = ready_r & ~RESET;
  assign CNT_ENABLE = cnt_enable_r;
  assign CNT_MODO   = cnt_modo_r;
  assign CNT_D      = cnt_d_r;
  assign DONE       = done_r;
  assign ERR        = err_r;
  assign RCO_SEEN   = rco_seen_r;

  // Sequencer FSM with its registered outputs and capture registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= S_IDLE;
      ready_r      <= 1'b1;
      cnt_enable_r <= 1'b0;
      cnt_modo_r   <= MODE_UP1;
      cnt_d_r      <= {WIDTH{1'b0}};
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      rco_seen_r   <= {CW{1'b0}};
      mode_r       <= MODE_UP1;
      d_r          <= {WIDTH{1'b0}};
      target_r     <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          err_r  <= 1'b0;
          if (REQ_VALID && ready_r) begin
            mode_r       <= REQ_MODE;
            d_r          <= REQ_D;
            target_r     <= REQ_TARGET;
            rco_seen_r   <= {CW{1'b0}};
            state_r      <= S_LOAD;
            ready_r      <= 1'b0;
            cnt_enable_r <= 1'b1;
            cnt_modo_r   <= MODE_LOAD;
            cnt_d_r      <= REQ_D;
          end else begin
            ready_r      <= 1'b1;
            cnt_enable_r <= 1'b0;
            cnt_modo_r   <= MODE_UP1;
            cnt_d_r      <= {WIDTH{1'b0}};
          end
        end

        S_LOAD: begin
          if ((mode_r == MODE_LOAD) || (target_r == {CW{1'b0}})) begin
            // Nothing to run: the load alone completes the command
            state_r      <= S_DONE;
            cnt_enable_r <= 1'b0;
            done_r       <= 1'b1;
            err_r        <= 1'b0;
          end else if (ABORT) begin
            state_r      <= S_DONE;
            cnt_enable_r <= 1'b0;
            done_r       <= 1'b1;
            err_r        <= 1'b1;
          end else begin
            state_r      <= S_RUN;
            cnt_enable_r <= 1'b1;
            cnt_modo_r   <= mode_r;
            cnt_d_r      <= d_r;
          end
        end

        S_RUN: begin
          if (CNT_RCO && (rco_seen_r != {CW{1'b1}})) begin
            rco_seen_r <= rco_seen_r + CW'(1);
          end else begin
            rco_seen_r <= rco_seen_r;
          end
          if (final_rco_s) begin
            // Completion takes priority over a simultaneous ABORT
            state_r      <= S_DONE;
            cnt_enable_r <= 1'b0;
            done_r       <= 1'b1;
            err_r        <= 1'b0;
          end else if (ABORT || (wd_expired_s && !CNT_RCO)) begin
            state_r      <= S_DONE;
            cnt_enable_r <= 1'b0;
            done_r       <= 1'b1;
            err_r        <= 1'b1;
          end else begin
            state_r      <= S_RUN;
            cnt_enable_r <= 1'b1;
          end
        end

        S_DONE: begin
          state_r      <= S_IDLE;
          ready_r      <= 1'b1;
          cnt_enable_r <= 1'b0;
          cnt_modo_r   <= MODE_UP1;
          cnt_d_r      <= {WIDTH{1'b0}};
          done_r       <= 1'b0;
          err_r        <= 1'b0;
        end

        default: begin
          state_r      <= S_IDLE;
          ready_r      <= 1'b1;
          cnt_enable_r <= 1'b0;
          cnt_modo_r   <= MODE_UP1;
          cnt_d_r      <= {WIDTH{1'b0}};
          done_r       <= 1'b0;
          err_r        <= 1'b0;
        end
      endcase
    end
  end

endmodule
